// File: rtl/irq_controller.sv
// Machine-level interrupt controller: software bit, prescaled timer/compare and edge-latched
// external lines, arbitrated into a single request/taken/mret handshake.
module irq_controller #(
    parameter int NUM_EXT  = 4,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic               mstatus_mie,
    input  logic               mie_msie,
    input  logic               mie_mtie,
    input  logic               mie_meie,
    input  logic               irq_taken,
    input  logic               mret,
    input  logic               bus_we,
    input  logic               bus_re,
    input  logic [4:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               interrupt,
    output logic [3:0]         irq_cause,
    output logic               in_service
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    localparam logic [2:0] REG_MSIP     = 3'd0;
    localparam logic [2:0] REG_MTIMECMP = 3'd1;
    localparam logic [2:0] REG_MTIME    = 3'd2;
    localparam logic [2:0] REG_EXT_EN   = 3'd3;
    localparam logic [2:0] REG_EXT_PEND = 3'd4;
    localparam logic [2:0] REG_CLAIM    = 3'd5;

    logic [1:0]         state;
    logic               msip;
    logic [31:0]        mtimecmp;
    logic [31:0]        mtime;
    logic [PW-1:0]      prescaler;
    logic [NUM_EXT-1:0] ext_en;
    logic [NUM_EXT-1:0] pend;
    logic [NUM_EXT-1:0] sync1;
    logic [NUM_EXT-1:0] sync2;
    logic [NUM_EXT-1:0] sync3;
    logic [4:0]         claim;
    logic [3:0]         req_id;

    logic [2:0]         reg_idx;
    logic               tick;
    logic [NUM_EXT-1:0] ext_rise;
    logic [NUM_EXT-1:0] active;
    logic [NUM_EXT-1:0] sel_mask;
    logic [NUM_EXT-1:0] w1c_mask;
    logic [NUM_EXT-1:0] claim_mask;
    logic               mtip;
    logic               mei;
    logic               msi;
    logic               mti;
    logic [3:0]         win_id;
    logic [3:0]         next_cause;
    logic               latched_ok;
    logic [31:0]        rd_data;
    logic               unused_addr;

    assign reg_idx     = bus_addr[4:2];
    assign unused_addr = ^bus_addr[1:0];
    assign tick        = (prescaler == PRE_MAX);

    assign ext_rise = sync2 & ~sync3;
    assign active   = pend & ext_en;
    assign sel_mask = NUM_EXT'(1) << req_id;

    assign mtip = (mtime >= mtimecmp);
    assign mei  = (|active) & mie_meie & mstatus_mie;
    assign msi  = msip & mie_msie & mstatus_mie;
    assign mti  = mtip & mie_mtie & mstatus_mie;

    assign w1c_mask   = (bus_we && reg_idx == REG_EXT_PEND) ? bus_wdata[NUM_EXT-1:0] : '0;
    assign claim_mask = (state == REQ && irq_taken && irq_cause == CAUSE_MEI) ? sel_mask : '0;

    // Lowest enabled pending index wins among external sources.
    always_comb begin
        win_id = '0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id = 4'(i);
            end
        end
    end

    always_comb begin
        if (mei) begin
            next_cause = CAUSE_MEI;
        end else if (msi) begin
            next_cause = CAUSE_MSI;
        end else if (mti) begin
            next_cause = CAUSE_MTI;
        end else begin
            next_cause = '0;
        end
    end

    // A request stays up only while the source it latched is still eligible.
    always_comb begin
        case (irq_cause)
            CAUSE_MEI: latched_ok = (|(active & sel_mask)) & mie_meie & mstatus_mie;
            CAUSE_MSI: latched_ok = msi;
            CAUSE_MTI: latched_ok = mti;
            default:   latched_ok = 1'b0;
        endcase
    end

    always_comb begin
        case (reg_idx)
            REG_MSIP:     rd_data = {31'b0, msip};
            REG_MTIMECMP: rd_data = mtimecmp;
            REG_MTIME:    rd_data = mtime;
            REG_EXT_EN:   rd_data = 32'(ext_en);
            REG_EXT_PEND: rd_data = 32'(pend);
            REG_CLAIM:    rd_data = 32'(claim);
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            mtime     <= '0;
            mtimecmp  <= '1;
            msip      <= 1'b0;
            ext_en    <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            if (bus_we && reg_idx == REG_MTIME) begin
                mtime <= bus_wdata;
            end else if (tick) begin
                mtime <= mtime + 32'd1;
            end
            if (bus_we && reg_idx == REG_MTIMECMP) begin
                mtimecmp <= bus_wdata;
            end
            if (bus_we && reg_idx == REG_MSIP) begin
                msip <= bus_wdata[0];
            end
            if (bus_we && reg_idx == REG_EXT_EN) begin
                ext_en <= bus_wdata[NUM_EXT-1:0];
            end
        end
    end

    // New edges are OR-ed in last so a coincident set beats a W1C or claim clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            pend  <= '0;
        end else begin
            sync1 <= ext_irq;
            sync2 <= sync1;
            sync3 <= sync2;
            pend  <= (pend & ~w1c_mask & ~claim_mask) | ext_rise;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_rdata <= '0;
        end else if (bus_re) begin
            bus_rdata <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            interrupt  <= 1'b0;
            irq_cause  <= '0;
            in_service <= 1'b0;
            req_id     <= '0;
            claim      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mei || msi || mti) begin
                        state     <= REQ;
                        interrupt <= 1'b1;
                        irq_cause <= next_cause;
                        req_id    <= win_id;
                    end
                end
                REQ: begin
                    if (irq_taken) begin
                        state      <= SERVICE;
                        interrupt  <= 1'b0;
                        in_service <= 1'b1;
                        if (irq_cause == CAUSE_MEI) begin
                            claim <= {1'b0, req_id} + 5'd1;
                        end
                    end else if (!latched_ok) begin
                        state     <= IDLE;
                        interrupt <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (mret) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    interrupt  <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized checks of irq_controller against a transaction-level model
// that tracks time, pending lines and the request handshake.
module tb_irq_controller;

    logic        clk         = 1'b0;
    logic        rst         = 1'b0;
    logic [3:0]  ext_irq     = '0;
    logic        mstatus_mie = 1'b0;
    logic        mie_msie    = 1'b0;
    logic        mie_mtie    = 1'b0;
    logic        mie_meie    = 1'b0;
    logic        irq_taken   = 1'b0;
    logic        mret        = 1'b0;
    logic        bus_we      = 1'b0;
    logic        bus_re      = 1'b0;
    logic [4:0]  bus_addr    = '0;
    logic [31:0] bus_wdata   = '0;
    logic [31:0] bus_rdata;
    logic        interrupt;
    logic [3:0]  irq_cause;
    logic        in_service;

    irq_controller #(.NUM_EXT(4), .PRESCALE(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_irq     (ext_irq),
        .mstatus_mie (mstatus_mie),
        .mie_msie    (mie_msie),
        .mie_mtie    (mie_mtie),
        .mie_meie    (mie_meie),
        .irq_taken   (irq_taken),
        .mret        (mret),
        .bus_we      (bus_we),
        .bus_re      (bus_re),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .interrupt   (interrupt),
        .irq_cause   (irq_cause),
        .in_service  (in_service)
    );

    always #5 clk = ~clk;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SVC  = 2;

    int checks = 0;
    int errors = 0;

    // Model: mtime is a base value plus elapsed cycles; ext history is a queue of samples.
    int unsigned cycle_count = 0;
    int unsigned base_cycle  = 0;
    logic [31:0] m_base;
    logic [31:0] m_cmp;
    logic        m_msip;
    logic [3:0]  m_en;
    logic [3:0]  m_pend;
    logic [4:0]  m_claim;
    int          m_phase;
    logic        m_int;
    logic [3:0]  m_cause;
    logic [1:0]  m_id;
    logic        m_insvc;
    logic [31:0] m_rdata;
    logic [3:0]  ext_hist[$];

    function automatic logic [31:0] cur_mtime();
        return m_base + (cycle_count - base_cycle);
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] idx);
        case (idx)
            3'd0:    return {31'b0, m_msip};
            3'd1:    return m_cmp;
            3'd2:    return cur_mtime();
            3'd3:    return {28'b0, m_en};
            3'd4:    return {28'b0, m_pend};
            3'd5:    return {27'b0, m_claim};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_base     = '0;
        base_cycle = cycle_count;
        m_cmp      = 32'hFFFF_FFFF;
        m_msip     = 1'b0;
        m_en       = '0;
        m_pend     = '0;
        m_claim    = '0;
        m_phase    = PH_IDLE;
        m_int      = 1'b0;
        m_cause    = '0;
        m_id       = '0;
        m_insvc    = 1'b0;
        m_rdata    = '0;
        ext_hist   = '{4'b0, 4'b0, 4'b0};
    endtask

    task automatic model_advance();
        logic [3:0]  rise;
        logic [3:0]  ready;
        logic [3:0]  clear;
        logic [1:0]  low;
        logic        found;
        logic        mei;
        logic        msi;
        logic        mti;
        logic        still;
        int          want;
        logic [31:0] rd;
        rise  = ext_hist[1] & ~ext_hist[2];
        ready = m_pend & m_en;
        found = 1'b0;
        low   = '0;
        for (int i = 0; i < 4; i++) begin
            if (ready[i] && !found) begin
                found = 1'b1;
                low   = 2'(i);
            end
        end
        mei   = found && mie_meie && mstatus_mie;
        msi   = m_msip && mie_msie && mstatus_mie;
        mti   = (cur_mtime() >= m_cmp) && mie_mtie && mstatus_mie;
        want  = mei ? 11 : msi ? 3 : mti ? 7 : 0;
        clear = '0;
        rd    = model_read(bus_addr[4:2]);
        case (m_phase)
            PH_IDLE: begin
                if (want != 0) begin
                    m_phase = PH_REQ;
                    m_int   = 1'b1;
                    m_cause = 4'(want);
                    if (mei) m_id = low;
                end
            end
            PH_REQ: begin
                if (irq_taken) begin
                    m_phase = PH_SVC;
                    m_int   = 1'b0;
                    m_insvc = 1'b1;
                    if (m_cause == 4'd11) begin
                        clear[m_id] = 1'b1;
                        m_claim     = {3'b0, m_id} + 5'd1;
                    end
                end else begin
                    if (m_cause == 4'd11)     still = ready[m_id] && mie_meie && mstatus_mie;
                    else if (m_cause == 4'd3) still = msi;
                    else                      still = mti;
                    if (!still) begin
                        m_phase = PH_IDLE;
                        m_int   = 1'b0;
                    end
                end
            end
            PH_SVC: begin
                if (mret) begin
                    m_phase = PH_IDLE;
                    m_insvc = 1'b0;
                end
            end
            default: ;
        endcase
        if (bus_re) m_rdata = rd;
        if (bus_we) begin
            case (bus_addr[4:2])
                3'd0: m_msip = bus_wdata[0];
                3'd1: m_cmp  = bus_wdata;
                3'd2: begin
                    m_base     = bus_wdata;
                    base_cycle = cycle_count + 1;
                end
                3'd3: m_en  = bus_wdata[3:0];
                3'd4: clear = clear | bus_wdata[3:0];
                default: ;
            endcase
        end
        m_pend = (m_pend & ~clear) | rise;
        ext_hist.push_front(ext_irq);
        void'(ext_hist.pop_back());
        cycle_count++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        checkOutput("interrupt", {31'b0, interrupt}, {31'b0, m_int});
        checkOutput("in_service", {31'b0, in_service}, {31'b0, m_insvc});
        checkOutput("bus_rdata", bus_rdata, m_rdata);
        if (m_int) checkOutput("irq_cause", {28'b0, irq_cause}, {28'b0, m_cause});
    endtask

    task automatic applyStimulus(input logic gie, input logic taken, input logic ret, input logic [3:0] ext);
        mstatus_mie = gie;
        irq_taken   = taken;
        mret        = ret;
        ext_irq     = ext;
        model_advance();
        @(posedge clk);
        #1;
        compare_all();
        irq_taken = 1'b0;
        mret      = 1'b0;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
        bus_we    = 1'b1;
        bus_addr  = {idx, 2'b00};
        bus_wdata = data;
        applyStimulus(mstatus_mie, 1'b0, 1'b0, ext_irq);
    endtask

    task automatic bus_read(input logic [2:0] idx);
        bus_re   = 1'b1;
        bus_addr = {idx, 2'b00};
        applyStimulus(mstatus_mie, 1'b0, 1'b0, ext_irq);
    endtask

    task automatic wait_irq(input int max_cycles, output int n);
        n = 0;
        while (!interrupt && n < max_cycles) begin
            applyStimulus(mstatus_mie, 1'b0, 1'b0, ext_irq);
            n++;
        end
        checkOutput("wait_irq", {31'b0, interrupt}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        $display("[TB] start");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_interrupt", {31'b0, interrupt}, 32'd0);
        checkOutput("rst_cause", {28'b0, irq_cause}, 32'd0);
        checkOutput("rst_in_service", {31'b0, in_service}, 32'd0);
        checkOutput("rst_rdata", bus_rdata, 32'd0);
        rst = 1'b1;

        bus_read(3'd1);
        checkOutput("rst_mtimecmp", bus_rdata, 32'hFFFF_FFFF);
        bus_read(3'd5);
        checkOutput("rst_claim", bus_rdata, 32'd0);

        // External line 0: edge to request takes four cycles.
        mie_msie = 1'b1;
        mie_mtie = 1'b1;
        mie_meie = 1'b1;
        mstatus_mie = 1'b1;
        bus_write(3'd3, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0001);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("ext_not_yet", {31'b0, interrupt}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("ext_irq", {31'b0, interrupt}, 32'd1);
        checkOutput("ext_cause", {28'b0, irq_cause}, 32'd11);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        checkOutput("ext_taken_svc", {31'b0, in_service}, 32'd1);
        bus_read(3'd4);
        checkOutput("ext_pend_cleared", bus_rdata, 32'd0);
        bus_read(3'd5);
        checkOutput("ext_claim", bus_rdata, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
        checkOutput("ext_mret", {31'b0, in_service}, 32'd0);

        // Timer compare at 10, then across the 32-bit wrap.
        bus_write(3'd2, 32'd0);
        bus_write(3'd1, 32'd10);
        wait_irq(30, n);
        checkOutput("timer_delay", 32'(n), 32'd10);
        checkOutput("timer_cause", {28'b0, irq_cause}, 32'd7);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
        bus_write(3'd2, 32'hFFFF_FFFE);
        bus_write(3'd1, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("wrap_no_irq", {31'b0, interrupt}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("wrap_irq", {31'b0, interrupt}, 32'd1);
        checkOutput("wrap_cause", {28'b0, irq_cause}, 32'd7);
        bus_read(3'd2);
        checkOutput("wrap_mtime", bus_rdata, 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        bus_write(3'd1, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);

        // All three classes pending together.
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        bus_write(3'd0, 32'd1);
        bus_write(3'd1, 32'd0);
        bus_write(3'd3, 32'hF);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0100);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("prio_mei", {28'b0, irq_cause}, 32'd11);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        bus_read(3'd5);
        checkOutput("prio_claim", bus_rdata, 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
        checkOutput("mret_gap", {31'b0, interrupt}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("prio_msi", {28'b0, irq_cause}, 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
        checkOutput("withdraw", {31'b0, interrupt}, 32'd0);
        bus_read(3'd0);
        checkOutput("withdraw_msip", bus_rdata, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        bus_write(3'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("prio_mti_irq", {31'b0, interrupt}, 32'd1);
        checkOutput("prio_mti", {28'b0, irq_cause}, 32'd7);

        // Collisions: taken while in service, and set-beats-W1C on line 1.
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        checkOutput("svc_taken_ignored", {31'b0, in_service}, 32'd1);
        bus_read(3'd5);
        checkOutput("svc_claim_kept", bus_rdata, 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0010);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000);
        bus_write(3'd4, 32'h2);
        bus_read(3'd4);
        checkOutput("w1c_collision", bus_rdata, 32'h2);
        bus_write(3'd4, 32'h2);
        bus_read(3'd4);
        checkOutput("w1c_plain", bus_rdata, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'b0000);
        wait_irq(5, n);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000);
        checkOutput("pre_reset_svc", {31'b0, in_service}, 32'd1);

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst = 1'b0;
        #1;
        checkOutput("arst_interrupt", {31'b0, interrupt}, 32'd0);
        checkOutput("arst_cause", {28'b0, irq_cause}, 32'd0);
        checkOutput("arst_in_service", {31'b0, in_service}, 32'd0);
        checkOutput("arst_rdata", bus_rdata, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus_read(3'd1);
        checkOutput("arst_mtimecmp", bus_rdata, 32'hFFFF_FFFF);
        bus_read(3'd5);
        checkOutput("arst_claim", bus_rdata, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [3:0] ext;
            logic       gie;
            logic       tk;
            logic       rt;
            int         r;
            ext = ext_irq;
            if ($urandom_range(0, 3) == 0) ext = ext ^ (4'b0001 << $urandom_range(0, 3));
            gie = ($urandom_range(0, 7) != 0);
            tk  = m_int ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            rt  = m_insvc ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            mie_msie = ($urandom_range(0, 9) != 0);
            mie_mtie = ($urandom_range(0, 9) != 0);
            mie_meie = ($urandom_range(0, 9) != 0);
            r = int'($urandom_range(0, 7));
            bus_addr  = 5'($urandom);
            bus_wdata = $urandom;
            bus_we    = (r == 0);
            bus_re    = (r == 1);
            applyStimulus(gie, tk, rt, ext);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
